uart_cmd_decoder: RTL and testbench

Frame-level command decoder between the UART receiver/transmitter and the PWM bank. It parses byte frames of the form start, command, length, payload, terminator. Validated commands are committed to the channel-enable mask or to per-channel duty writes, and every complete frame is answered with a one-byte ACK/NAK. It generalises the fixed 64-channel command path to a parametrised channel count, and adds length checking, an inter-byte timeout and a response.

---
 rtl/uart_cmd_decoder.sv | 171 +++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Frame-level command decoder: parses START/CMD/LEN/PAYLOAD/END frames from the UART,
// commits channel-enable or duty writes, and answers each complete frame with ACK/NAK.
module uart_cmd_decoder #(
  parameter int unsigned G_CHANNELS = 64,
  parameter int unsigned G_DUTY_W   = 8,
  parameter int unsigned G_TIMEOUT  = 30000,
  parameter logic [7:0]  G_START    = 8'h4B,
  parameter logic [7:0]  G_END      = 8'h0D
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_vld,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_start,
  input  logic                          i_tx_busy,
  output logic [G_CHANNELS-1:0]         o_pwm_en,
  output logic                          o_duty_we,
  output logic                          o_duty_all,
  output logic [$clog2(G_CHANNELS)-1:0] o_duty_ch,
  output logic [G_DUTY_W-1:0]           o_duty_val
);

  localparam int unsigned ChW      = $clog2(G_CHANNELS);
  localparam int unsigned TmoW     = $clog2(G_TIMEOUT + 1);
  // SET_DUTY needs two payload bytes even when the channel mask is a single byte wide
  localparam int unsigned BufW     = (G_CHANNELS > 16) ? G_CHANNELS : 16;
  localparam int unsigned NumBytes = BufW / 8;
  localparam logic [8:0]  EnBytes  = 9'(G_CHANNELS / 8);
  localparam logic [8:0]  NumChan  = 9'(G_CHANNELS);
  localparam logic [7:0]  Ack      = 8'h06;
  localparam logic [7:0]  Nak      = 8'h15;

  localparam logic [7:0] CmdSetAll  = 8'h00;
  localparam logic [7:0] CmdSetDuty = 8'h01;
  localparam logic [7:0] CmdSetEn   = 8'h02;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StLen,
    StPayload,
    StTerm,
    StResp
  } state_e;

  state_e            state_q;
  logic [7:0]        cmd_q;
  logic [7:0]        len_q;
  logic [8:0]        cnt_q;
  logic              err_q;
  logic [TmoW-1:0]   tmo_q;
  logic [BufW-1:0]   buf_q;
  logic [8:0]        exp_cnt;

  // Payload length each command requires; zero marks an invalid command.
  always_comb begin
    exp_cnt = 9'd0;
    case (cmd_q)
      CmdSetAll:  exp_cnt = 9'd1;
      CmdSetDuty: exp_cnt = 9'd2;
      CmdSetEn:   exp_cnt = EnBytes;
      default:    exp_cnt = 9'd0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      buf_q      <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_pwm_en   <= '0;
      o_duty_we  <= 1'b0;
      o_duty_all <= 1'b0;
      o_duty_ch  <= '0;
      o_duty_val <= '0;
    end else begin
      o_tx_start <= 1'b0;
      o_duty_we  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tmo_q <= '0;
          if (i_rx_vld && (i_rx_data == G_START)) begin
            state_q <= StCmd;
            err_q   <= 1'b0;
          end
        end

        StCmd, StLen, StPayload, StTerm: begin
          if (i_rx_vld) begin
            tmo_q <= '0;
            case (state_q)
              StCmd: begin
                cmd_q   <= i_rx_data;
                state_q <= StLen;
                if (i_rx_data > CmdSetEn) err_q <= 1'b0 | 1'b1;
              end
              StLen: begin
                len_q   <= i_rx_data;
                cnt_q   <= '0;
                state_q <= StPayload;
                if (({1'b0, i_rx_data} + 9'd1) != exp_cnt) err_q <= 1'b1;
              end
              StPayload: begin
                if (cnt_q < exp_cnt) begin
                  for (int unsigned k = 0; k < NumBytes; k++) begin
                    if (cnt_q == 9'(k)) buf_q[8*k +: 8] <= i_rx_data;
                  end
                end else begin
                  err_q <= 1'b1;
                end
                if ((cmd_q == CmdSetDuty) && (cnt_q == 9'd0) && ({1'b0, i_rx_data} >= NumChan)) begin
                  err_q <= 1'b1;
                end
                cnt_q <= cnt_q + 9'd1;
                if (cnt_q == {1'b0, len_q}) state_q <= StTerm;
              end
              default: begin
                // Terminator byte: commit only on a clean frame
                if ((i_rx_data == G_END) && !err_q) begin
                  o_tx_data <= Ack;
                  case (cmd_q)
                    CmdSetAll: begin
                      o_duty_we  <= 1'b1;
                      o_duty_all <= 1'b1;
                      o_duty_val <= buf_q[G_DUTY_W-1:0];
                    end
                    CmdSetDuty: begin
                      o_duty_we  <= 1'b1;
                      o_duty_all <= 1'b0;
                      o_duty_ch  <= buf_q[ChW-1:0];
                      o_duty_val <= buf_q[8 +: G_DUTY_W];
                    end
                    default: o_pwm_en <= buf_q[G_CHANNELS-1:0];
                  endcase
                end else begin
                  o_tx_data <= Nak;
                end
                o_tx_start <= !i_tx_busy;
                state_q    <= StResp;
              end
            endcase
          end else if (tmo_q == TmoW'(G_TIMEOUT)) begin
            state_q <= StIdle;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end

        StResp: begin
          // Leave once the single start pulse has been issued; incoming bytes are dropped
          if (o_tx_start) begin
            state_q <= StIdle;
          end else if (!i_tx_busy) begin
            o_tx_start <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder with 64 channels and a short timeout.
module tb_uart_cmd_decoder;

  localparam int unsigned Chan    = 64;
  localparam int unsigned Timeout = 40;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [63:0] pwm_en;
  logic        duty_we;
  logic        duty_all;
  logic [5:0]  duty_ch;
  logic [7:0]  duty_val;

  uart_cmd_decoder #(
    .G_CHANNELS (Chan),
    .G_DUTY_W   (8),
    .G_TIMEOUT  (Timeout),
    .G_START    (8'h4B),
    .G_END      (8'h0D)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_vld   (rx_vld),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .i_tx_busy  (tx_busy),
    .o_pwm_en   (pwm_en),
    .o_duty_we  (duty_we),
    .o_duty_all (duty_all),
    .o_duty_ch  (duty_ch),
    .o_duty_val (duty_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Event monitor, sampled on the falling edge away from DUT updates
  int         tx_cnt = 0;
  int         we_cnt = 0;
  logic [7:0] last_tx = '0;
  logic [5:0] last_ch = '0;
  logic [7:0] last_val = '0;
  logic       last_all = 1'b0;

  always @(negedge clk) begin
    if (tx_start) begin
      tx_cnt  = tx_cnt + 1;
      last_tx = tx_data;
    end
    if (duty_we) begin
      we_cnt   = we_cnt + 1;
      last_ch  = duty_ch;
      last_val = duty_val;
      last_all = duty_all;
    end
  end

  logic [7:0] frame_q[$];
  int         tx_base;
  int         we_base;
  logic [63:0] en_exp;

  task automatic send_frame();
    foreach (frame_q[i]) begin
      @(negedge clk);
      rx_data = frame_q[i];
      rx_vld  = 1'b1;
    end
    @(negedge clk);
    rx_vld = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    tx_base = tx_cnt;
    we_base = we_cnt;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_vld = 1'b0; rx_data = '0; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);
    checks++;
    if (pwm_en !== 64'h0) $display("FAIL reset_pwm_en got %h want 0", pwm_en); else passed++;
    checks++;
    if (tx_start !== 1'b0 || duty_we !== 1'b0) $display("FAIL reset_strobes got %b%b want 00", tx_start, duty_we); else passed++;
    checks++;
    if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else passed++;
  endtask

  task automatic test_set_all();
    snap();
    frame_q = '{8'h4B, 8'h00, 8'h00, 8'h12, 8'h0D};
    send_frame();
    // One cycle after the terminator edge
    checks++;
    if (duty_we !== 1'b1 || duty_all !== 1'b1 || duty_val !== 8'h12)
      $display("FAIL set_all_strobe got we=%b all=%b val=%h want 1 1 12", duty_we, duty_all, duty_val);
    else passed++;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h06)
      $display("FAIL set_all_tx got start=%b data=%h want 1 06", tx_start, tx_data);
    else passed++;
    wait_cycles(5);
    checks++;
    if (we_cnt - we_base != 1 || tx_cnt - tx_base != 1)
      $display("FAIL set_all_counts got we=%0d tx=%0d want 1 1", we_cnt - we_base, tx_cnt - tx_base);
    else passed++;
  endtask

  task automatic test_set_en();
    snap();
    frame_q = '{8'h4B, 8'h02, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0D};
    send_frame();
    wait_cycles(5);
    en_exp = 64'h0807060504030201;
    checks++;
    if (pwm_en !== en_exp) $display("FAIL set_en_mask got %h want %h", pwm_en, en_exp); else passed++;
    checks++;
    if (tx_cnt - tx_base != 1 || last_tx !== 8'h06)
      $display("FAIL set_en_ack got n=%0d data=%h want 1 06", tx_cnt - tx_base, last_tx);
    else passed++;
    snap();
    frame_q = '{8'h4B, 8'h02, 8'h06, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h0D};
    send_frame();
    wait_cycles(5);
    checks++;
    if (pwm_en !== en_exp) $display("FAIL set_en_short_mask got %h want %h", pwm_en, en_exp); else passed++;
    checks++;
    if (tx_cnt - tx_base != 1 || last_tx !== 8'h15)
      $display("FAIL set_en_short_nak got n=%0d data=%h want 1 15", tx_cnt - tx_base, last_tx);
    else passed++;
  endtask

  task automatic test_set_duty();
    snap();
    frame_q = '{8'h4B, 8'h01, 8'h01, 8'h3F, 8'h80, 8'h0D};
    send_frame();
    wait_cycles(5);
    checks++;
    if (we_cnt - we_base != 1 || last_ch !== 6'd63 || last_val !== 8'h80 || last_all !== 1'b0)
      $display("FAIL set_duty_63 got n=%0d ch=%0d val=%h all=%b want 1 63 80 0",
               we_cnt - we_base, last_ch, last_val, last_all);
    else passed++;
    checks++;
    if (tx_cnt - tx_base != 1 || last_tx !== 8'h06)
      $display("FAIL set_duty_63_ack got n=%0d data=%h want 1 06", tx_cnt - tx_base, last_tx);
    else passed++;
    snap();
    frame_q = '{8'h4B, 8'h01, 8'h01, 8'h40, 8'h80, 8'h0D};
    send_frame();
    wait_cycles(5);
    checks++;
    if (we_cnt - we_base != 0) $display("FAIL set_duty_64_strobe got %0d want 0", we_cnt - we_base); else passed++;
    checks++;
    if (tx_cnt - tx_base != 1 || last_tx !== 8'h15)
      $display("FAIL set_duty_64_nak got n=%0d data=%h want 1 15", tx_cnt - tx_base, last_tx);
    else passed++;
  endtask

  task automatic test_errors();
    snap();
    frame_q = '{8'h4B, 8'h05, 8'h00, 8'h00, 8'h0D};
    send_frame();
    wait_cycles(5);
    checks++;
    if (tx_cnt - tx_base != 1 || last_tx !== 8'h15 || we_cnt != we_base)
      $display("FAIL bad_cmd got n=%0d data=%h we=%0d want 1 15 0", tx_cnt - tx_base, last_tx, we_cnt - we_base);
    else passed++;
    snap();
    frame_q = '{8'h4B, 8'h00, 8'h00, 8'h12, 8'h0A};
    send_frame();
    wait_cycles(5);
    checks++;
    if (tx_cnt - tx_base != 1 || last_tx !== 8'h15 || we_cnt != we_base)
      $display("FAIL bad_term got n=%0d data=%h we=%0d want 1 15 0", tx_cnt - tx_base, last_tx, we_cnt - we_base);
    else passed++;
    snap();
    frame_q = '{8'h55, 8'h4B, 8'h00, 8'h00, 8'h34, 8'h0D};
    send_frame();
    wait_cycles(5);
    checks++;
    if (tx_cnt - tx_base != 1 || last_tx !== 8'h06 || we_cnt - we_base != 1 || last_val !== 8'h34)
      $display("FAIL lead_junk got n=%0d data=%h we=%0d val=%h want 1 06 1 34",
               tx_cnt - tx_base, last_tx, we_cnt - we_base, last_val);
    else passed++;
  endtask

  task automatic test_timeout();
    snap();
    frame_q = '{8'h4B, 8'h02};
    send_frame();
    wait_cycles(Timeout + 5);
    // After a timeout these bytes arrive in IDLE and must be ignored
    frame_q = '{8'h00, 8'h00, 8'h12, 8'h0D};
    send_frame();
    wait_cycles(5);
    checks++;
    if (tx_cnt - tx_base != 0 || we_cnt - we_base != 0)
      $display("FAIL timeout_silent got tx=%0d we=%0d want 0 0", tx_cnt - tx_base, we_cnt - we_base);
    else passed++;
    snap();
    frame_q = '{8'h4B, 8'h00, 8'h00};
    send_frame();
    wait_cycles(Timeout - 5);
    frame_q = '{8'h21, 8'h0D};
    send_frame();
    wait_cycles(5);
    checks++;
    if (tx_cnt - tx_base != 1 || last_tx !== 8'h06 || last_val !== 8'h21)
      $display("FAIL gap_under_timeout got n=%0d data=%h val=%h want 1 06 21", tx_cnt - tx_base, last_tx, last_val);
    else passed++;
  endtask

  task automatic test_busy();
    int early;
    snap();
    @(negedge clk);
    tx_busy = 1'b1;
    frame_q = '{8'h4B, 8'h00, 8'h00, 8'h56, 8'h0D};
    send_frame();
    checks++;
    if (duty_we !== 1'b1 || duty_val !== 8'h56)
      $display("FAIL busy_duty got we=%b val=%h want 1 56", duty_we, duty_val);
    else passed++;
    repeat (90) @(negedge clk);
    early = tx_cnt - tx_base;
    checks++;
    if (early != 0 || tx_start !== 1'b0) $display("FAIL busy_hold got n=%0d start=%b want 0 0", early, tx_start); else passed++;
    tx_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h06)
      $display("FAIL busy_release got start=%b data=%h want 1 06", tx_start, tx_data);
    else passed++;
    wait_cycles(5);
    checks++;
    if (tx_cnt - tx_base != 1) $display("FAIL busy_once got %0d want 1", tx_cnt - tx_base); else passed++;
  endtask

  task automatic test_back_to_back();
    snap();
    frame_q = '{8'h4B, 8'h01, 8'h01, 8'h05, 8'h77, 8'h0D, 8'h4B, 8'h01, 8'h01, 8'h06, 8'h78, 8'h0D};
    send_frame();
    wait_cycles(5);
    // Second frame's START lands while responding and is dropped, so only one ACK
    checks++;
    if (tx_cnt - tx_base != 1 || we_cnt - we_base != 1 || last_ch !== 6'd5 || last_val !== 8'h77)
      $display("FAIL b2b got tx=%0d we=%0d ch=%0d val=%h want 1 1 5 77",
               tx_cnt - tx_base, we_cnt - we_base, last_ch, last_val);
    else passed++;
  endtask

  task automatic test_reset_mid();
    snap();
    frame_q = '{8'h4B, 8'h02, 8'h07, 8'h11, 8'h22};
    send_frame();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pwm_en !== 64'h0 || tx_data !== 8'h00)
      $display("FAIL reset_mid_out got en=%h data=%h want 0 00", pwm_en, tx_data);
    else passed++;
    rst = 1'b0;
    frame_q = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h0D};
    send_frame();
    wait_cycles(5);
    checks++;
    if (tx_cnt - tx_base != 0 || pwm_en !== 64'h0)
      $display("FAIL reset_mid_resp got tx=%0d en=%h want 0 0", tx_cnt - tx_base, pwm_en);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_set_all();
    test_set_en();
    test_set_duty();
    test_errors();
    test_timeout();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
